code_lock_fsm: RTL

- Parametrised successor to the fixed 8-digit keypad lock.
- Code length, digit width and code value are parameters.
- Digits are compared without revealing which one was wrong; failures are counted, with a timed lockout after too many. Unlock and fail indications are timed.
- Sits between the debounced keypad front end (one-cycle `equals` strobes) and the door actuator/status LEDs.

---
 rtl/code_lock_pkg.sv | 34 +++
 rtl/code_lock_hold_timer.sv | 31 +++
 rtl/code_lock_fsm.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/code_lock_pkg.sv
// Shared types and width helpers for the parametrised keypad code lock.
package code_lock_pkg;

  // Lock controller states; PROG is only reachable in builds with code programming.
  typedef enum logic [2:0] {
    ENTRY    = 3'd0,
    UNLOCKED = 3'd1,
    FAILED   = 3'd2,
    LOCKOUT  = 3'd3,
    PROG     = 3'd4
  } lock_state_t;

  // Bits needed to hold a counter value from 0 up to max_value inclusive.
  function automatic int count_width(input int max_value);
    if (max_value < 1) begin
      return 1;
    end
    return $clog2(max_value + 1);
  endfunction

  // Bits for the shared hold timer: one more than $clog2 of the longest hold.
  function automatic int timer_width(input int hold_a, input int hold_b, input int hold_c);
    int longest;
    longest = hold_a;
    if (hold_b > longest) begin
      longest = hold_b;
    end
    if (hold_c > longest) begin
      longest = hold_c;
    end
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/code_lock_hold_timer.sv
// Loadable down-counter shared by all timed lock states.
// done is high whenever the count has reached zero; the owner decides
// when that matters.
module hold_timer
  import code_lock_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// Parametrised keypad code lock controller.
// Accepts one digit per equals strobe, compares the full entry against the
// code without revealing which digit was wrong, and drives timed unlock,
// fail and lockout indications. Consecutive failures are counted and
// MAX_FAILS of them in a row trigger a lockout.
// Optional feature macro: CODE_PROG_EN adds the prog_req input and a PROG
// state that lets the code be rewritten while unlocked.
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int                           CODE_LEN       = 8,
  parameter int                           DIGIT_W        = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]  CODE           = 32'h3900_8121,
  parameter int                           MAX_FAILS      = 3,
  parameter int                           UNLOCK_CYCLES  = 1024,
  parameter int                           FAIL_CYCLES    = 256,
  parameter int                           LOCKOUT_CYCLES = 65536
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  equals,
  input  logic [DIGIT_W-1:0]                    digit,
  input  logic                                  clear,
`ifdef CODE_PROG_EN
  input  logic                                  prog_req,
`endif
  output logic                                  door_status_correct,
  output logic                                  door_status_incorrect,
  output logic                                  locked_out,
  output logic [count_width(CODE_LEN)-1:0]      digit_count,
  output logic [count_width(MAX_FAILS)-1:0]     fail_count
);

  localparam int CODE_W  = CODE_LEN * DIGIT_W;
  localparam int DC_W    = count_width(CODE_LEN);
  localparam int FC_W    = count_width(MAX_FAILS);
  localparam int TIMER_W = timer_width(UNLOCK_CYCLES, FAIL_CYCLES, LOCKOUT_CYCLES);

  localparam logic [DC_W-1:0]    LAST_DIGIT   = DC_W'(CODE_LEN - 1);
  localparam logic [FC_W-1:0]    FAIL_LIMIT   = FC_W'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FAIL_LOAD    = TIMER_W'(FAIL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

  lock_state_t          state;
  lock_state_t          state_next;
  logic [DC_W-1:0]      digit_count_next;
  logic [FC_W-1:0]      fail_count_next;
  logic                 mismatch;
  logic                 mismatch_next;
  logic                 entry_miss;
  logic [DIGIT_W-1:0]   expected_digit;
  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_value;
  logic                 timer_done;
  logic [CODE_W-1:0]    code_reg;

`ifdef CODE_PROG_EN
  logic [CODE_W-1:0]    code_next;
  logic [CODE_W-1:0]    shadow;
  logic [CODE_W-1:0]    shadow_next;

  // Programmable code and the shadow copy being keyed in; only reset restores CODE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_reg <= CODE;
      shadow   <= '0;
    end else begin
      code_reg <= code_next;
      shadow   <= shadow_next;
    end
  end
`else
  assign code_reg = CODE;
`endif

  // Pick the code digit for the current position; the first digit sits in the top slot.
  always_comb begin
    expected_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_count == DC_W'(i)) begin
        expected_digit = code_reg[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Sticky mismatch including the digit being keyed right now.
  assign entry_miss = mismatch | (digit != expected_digit);

  // One shared timer for every timed state, reloaded whenever such a state is entered.
  hold_timer #(
    .W(TIMER_W)
  ) u_hold_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // Next-state, counter updates and timer loads for every state.
  always_comb begin
    state_next       = state;
    digit_count_next = digit_count;
    fail_count_next  = fail_count;
    mismatch_next    = mismatch;
    timer_load       = 1'b0;
    timer_value      = '0;
`ifdef CODE_PROG_EN
    code_next        = code_reg;
    shadow_next      = shadow;
`endif
    case (state)
      ENTRY: begin
        if (clear) begin
          digit_count_next = '0;
          mismatch_next    = 1'b0;
        end else if (equals) begin
          if (digit_count == LAST_DIGIT) begin
            digit_count_next = '0;
            mismatch_next    = 1'b0;
            timer_load       = 1'b1;
            if (entry_miss) begin
              state_next  = FAILED;
              timer_value = FAIL_LOAD;
              if (fail_count != FAIL_LIMIT) begin
                fail_count_next = fail_count + FC_W'(1);
              end
            end else begin
              state_next      = UNLOCKED;
              timer_value     = UNLOCK_LOAD;
              fail_count_next = '0;
            end
          end else begin
            digit_count_next = digit_count + DC_W'(1);
            mismatch_next    = entry_miss;
          end
        end
      end
      UNLOCKED: begin
`ifdef CODE_PROG_EN
        if (prog_req) begin
          state_next       = PROG;
          digit_count_next = '0;
        end else if (timer_done) begin
          state_next = ENTRY;
        end
`else
        if (timer_done) begin
          state_next = ENTRY;
        end
`endif
      end
      FAILED: begin
        if (timer_done) begin
          if (fail_count == FAIL_LIMIT) begin
            state_next  = LOCKOUT;
            timer_load  = 1'b1;
            timer_value = LOCKOUT_LOAD;
          end else begin
            state_next = ENTRY;
          end
        end
      end
      LOCKOUT: begin
        if (timer_done) begin
          state_next      = ENTRY;
          fail_count_next = '0;
        end
      end
`ifdef CODE_PROG_EN
      PROG: begin
        if (clear) begin
          state_next       = ENTRY;
          digit_count_next = '0;
          shadow_next      = '0;
        end else if (equals) begin
          for (int i = 0; i < CODE_LEN; i++) begin
            if (digit_count == DC_W'(i)) begin
              shadow_next[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
            end
          end
          if (digit_count == LAST_DIGIT) begin
            code_next        = shadow_next;
            state_next       = ENTRY;
            digit_count_next = '0;
          end else begin
            digit_count_next = digit_count + DC_W'(1);
          end
        end
      end
`endif
      default: begin
        state_next       = ENTRY;
        digit_count_next = '0;
        mismatch_next    = 1'b0;
      end
    endcase
  end

  // State, entry progress and failure count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ENTRY;
      digit_count <= '0;
      fail_count  <= '0;
      mismatch    <= 1'b0;
    end else begin
      state       <= state_next;
      digit_count <= digit_count_next;
      fail_count  <= fail_count_next;
      mismatch    <= mismatch_next;
    end
  end

  // Status outputs registered from the next state so each tracks its state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      door_status_correct   <= 1'b0;
      door_status_incorrect <= 1'b0;
      locked_out            <= 1'b0;
    end else begin
      door_status_correct   <= (state_next == UNLOCKED);
      door_status_incorrect <= (state_next == FAILED);
      locked_out            <= (state_next == LOCKOUT);
    end
  end

endmodule
